// File: rtl/alu_rv_pipe.sv
// alu_rv_pipe: two-stage valid/ready RV integer ALU (R-type and I-type ALU ops).
// Define ALU_RV_MUL_EN to add MUL/MULH/MULHSU/MULHU, computed in stage 2.
module alu_rv_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [TAG_W-1:0] in_tag,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    input  logic [XLEN-1:0]  rs1_value,
    input  logic [XLEN-1:0]  rs2_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_result,
    output logic             out_we,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
    } op_t;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic            sh_zero, sra_ok;
    op_t             dec_op;
    logic            dec_ill;
    logic [XLEN-1:0] dec_b;

    logic            s1_valid, s1_ill;
    op_t             s1_op;
    logic [4:0]      s1_rd;
    logic [XLEN-1:0] s1_a, s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic            s2_valid;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu;
    logic            adv1, adv2;

    assign opcode  = instruction[6:0];
    assign funct3  = instruction[14:12];
    assign funct7  = instruction[31:25];
    assign rs1     = instruction[19:15];
    assign rs2     = instruction[24:20];
    assign imm     = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign sh_zero = (XLEN == 64) ? (instruction[31:26] == 6'b000000) : (instruction[31:25] == 7'b0000000);
    assign sra_ok  = (XLEN == 64) ? (instruction[31:26] == 6'b010000) : (instruction[31:25] == 7'b0100000);

    function automatic op_t base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        dec_b   = rs2_value;
        if (opcode == 7'b0110011) begin
            if (funct7 == 7'b0000000)
                dec_op = base_op(funct3);
            else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                dec_op = OP_SUB;
            else if (funct7 == 7'b0100000 && funct3 == 3'b101)
                dec_op = OP_SRA;
`ifdef ALU_RV_MUL_EN
            else if (funct7 == 7'b0000001 && !funct3[2])
                dec_op = funct3[1] ? (funct3[0] ? OP_MULHU : OP_MULHSU) : (funct3[0] ? OP_MULH : OP_MUL);
`endif
            else
                dec_ill = 1'b1;
        end else if (opcode == 7'b0010011) begin
            dec_b  = imm;
            dec_op = base_op(funct3);
            // Shift-immediate forms reuse the upper immediate bits as a funct field
            if (funct3 == 3'b001)
                dec_ill = !sh_zero;
            else if (funct3 == 3'b101) begin
                dec_op  = sra_ok ? OP_SRA : OP_SRL;
                dec_ill = !(sh_zero || sra_ok);
            end
        end else
            dec_ill = 1'b1;
    end

`ifdef ALU_RV_MUL_EN
    logic            sign_a, sign_b;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    assign sign_a = (s1_op == OP_MULH) || (s1_op == OP_MULHSU);
    assign sign_b = (s1_op == OP_MULH);
    // Extending each operand to 2*XLEN makes one unsigned multiplier serve all signedness mixes
    assign mul_a  = {{XLEN{sign_a & s1_a[XLEN-1]}}, s1_a};
    assign mul_b  = {{XLEN{sign_b & s1_b[XLEN-1]}}, s1_b};
    assign prod   = mul_a * mul_b;
`endif

    assign shamt = s1_b[SH_W-1:0];

    always_comb begin
        alu = '0;
        case (s1_op)
            OP_ADD:    alu = s1_a + s1_b;
            OP_SUB:    alu = s1_a - s1_b;
            OP_SLL:    alu = s1_a << shamt;
            OP_SLT:    alu = {{(XLEN-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
            OP_SLTU:   alu = {{(XLEN-1){1'b0}}, s1_a < s1_b};
            OP_XOR:    alu = s1_a ^ s1_b;
            OP_SRL:    alu = s1_a >> shamt;
            OP_SRA:    alu = $unsigned($signed(s1_a) >>> shamt);
            OP_OR:     alu = s1_a | s1_b;
            OP_AND:    alu = s1_a & s1_b;
`ifdef ALU_RV_MUL_EN
            OP_MUL:    alu = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  alu = prod[2*XLEN-1:XLEN];
`endif
            default:   alu = '0;
        endcase
    end

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 && !reset && !flush;
    assign out_valid = s2_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_ill      <= 1'b0;
            s1_op       <= OP_ADD;
            s1_rd       <= '0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            out_rd      <= '0;
            out_result  <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_rd      <= s1_rd;
                    out_result  <= s1_ill ? '0 : alu;
                    out_we      <= !s1_ill && (s1_rd != 5'd0);
                    out_illegal <= s1_ill;
                    out_tag     <= s1_tag;
                end
            end
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op  <= dec_op;
                    s1_ill <= dec_ill;
                    s1_rd  <= instruction[11:7];
                    s1_a   <= rs1_value;
                    s1_b   <= dec_b;
                    s1_tag <= in_tag;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rv_pipe.sv
// tb_alu_rv_pipe: directed vector table plus stall, flush and reset sequences for alu_rv_pipe.
module tb_alu_rv_pipe;
    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_ready, out_valid;
    logic [31:0] instruction, in_tag, rs1_value, rs2_value, out_result, out_tag;
    logic [4:0]  rs1, rs2, out_rd;
    logic        out_we, out_illegal;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t vt[28];
    vec_t st[4];

    alu_rv_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction), .in_tag(in_tag),
        .rs1(rs1), .rs2(rs2), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_result(out_result),
        .out_we(out_we), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        return {f7, s2, s1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] im, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] s1);
        return {im, s1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [31:0] tag);
        in_valid    = 1'b1;
        instruction = v.instr;
        rs1_value   = v.a;
        rs2_value   = v.b;
        in_tag      = tag;
    endtask

    task automatic check_out(input string name, input vec_t v, input logic [31:0] tag);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_rd"}, out_rd, v.rd);
        chk({name, "_result"}, out_result, v.res);
        chk({name, "_we"}, out_we, v.we);
        chk({name, "_illegal"}, out_illegal, v.ill);
        chk({name, "_tag"}, out_tag, tag);
    endtask

    task automatic apply(input string name, input vec_t v, input logic [31:0] tag);
        @(negedge clock);
        drive(v, tag);
        #1;
        chk({name, "_rs1"}, rs1, v.instr[19:15]);
        chk({name, "_rs2"}, rs2, v.instr[24:20]);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        check_out(name, v, tag);
    endtask

    task automatic run_stream(input string name, input int n, input int stall);
        int sent = 0;
        int got = 0;
        int drop_at = -1;
        logic [31:0] held = '0;
        logic held_seen = 1'b0;
        for (int c = 0; c < 40 && got < n; c++) begin
            @(negedge clock);
            out_ready = (c >= stall);
            in_valid  = 1'b0;
            if (sent < n) drive(st[sent], 32'h200 + sent);
            #1;
            if (out_valid && !out_ready) begin
                if (held_seen) chk({name, "_hold"}, out_result, held);
                held = out_result;
                held_seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                check_out($sformatf("%s_%0d", name, got), st[got], 32'h200 + got);
                got++;
            end
            if (in_valid && in_ready) sent++;
            else if (in_valid && drop_at < 0) drop_at = sent;
        end
        in_valid = 1'b0;
        chk({name, "_count"}, got, n);
        if (stall > 0) chk({name, "_accepts_before_stall"}, drop_at, 2);
    endtask

    initial begin
        vt[0]  = '{r_t(7'h00, 3'b000, 3, 1, 2), 32'h7FFFFFFF, 32'h1, 3, 32'h80000000, 1, 0};
        vt[1]  = '{i_t(12'h404, 3'b101, 5, 6), 32'hF0000000, 32'hDEADBEEF, 5, 32'hFF000000, 1, 0};
        vt[2]  = '{i_t(12'h004, 3'b101, 5, 6), 32'hF0000000, 32'hDEADBEEF, 5, 32'h0F000000, 1, 0};
        vt[3]  = '{i_t(12'hFFF, 3'b011, 7, 6), 32'h5, 32'hDEADBEEF, 7, 32'h1, 1, 0};
        vt[4]  = '{r_t(7'h20, 3'b000, 4, 1, 2), 32'h0, 32'h1, 4, 32'hFFFFFFFF, 1, 0};
        vt[5]  = '{r_t(7'h00, 3'b010, 4, 1, 2), 32'hFFFFFFFF, 32'h1, 4, 32'h1, 1, 0};
        vt[6]  = '{r_t(7'h00, 3'b011, 4, 1, 2), 32'hFFFFFFFF, 32'h1, 4, 32'h0, 1, 0};
        vt[7]  = '{r_t(7'h00, 3'b100, 4, 1, 2), 32'h0000F0F0, 32'h0000FF00, 4, 32'h00000FF0, 1, 0};
        vt[8]  = '{r_t(7'h00, 3'b110, 4, 1, 2), 32'h0000F0F0, 32'h0000FF00, 4, 32'h0000FFF0, 1, 0};
        vt[9]  = '{r_t(7'h00, 3'b111, 4, 1, 2), 32'h0000F0F0, 32'h0000FF00, 4, 32'h0000F000, 1, 0};
        vt[10] = '{r_t(7'h00, 3'b001, 4, 1, 2), 32'h1, 32'h23, 4, 32'h8, 1, 0};
        vt[11] = '{r_t(7'h20, 3'b101, 4, 1, 2), 32'h80000000, 32'h1F, 4, 32'hFFFFFFFF, 1, 0};
        vt[12] = '{r_t(7'h00, 3'b101, 4, 1, 2), 32'h80000000, 32'h1F, 4, 32'h1, 1, 0};
        vt[13] = '{i_t(12'h005, 3'b000, 0, 1), 32'hA, 32'hDEADBEEF, 0, 32'hF, 0, 0};
        vt[14] = '{i_t(12'hFFF, 3'b010, 8, 1), 32'hFFFFFFFE, 32'hDEADBEEF, 8, 32'h1, 1, 0};
        vt[15] = '{i_t(12'hFFF, 3'b100, 9, 1), 32'h0000000F, 32'hDEADBEEF, 9, 32'hFFFFFFF0, 1, 0};
        vt[16] = '{i_t(12'h0F0, 3'b111, 9, 1), 32'h12345678, 32'hDEADBEEF, 9, 32'h00000070, 1, 0};
        vt[17] = '{i_t(12'h800, 3'b110, 9, 1), 32'h1, 32'hDEADBEEF, 9, 32'hFFFFF801, 1, 0};
        vt[18] = '{i_t(12'h023, 3'b001, 9, 1), 32'h1, 32'h0, 9, 32'h0, 0, 1};
        vt[19] = '{i_t(12'h604, 3'b101, 9, 1), 32'h80000000, 32'h0, 9, 32'h0, 0, 1};
        vt[20] = '{r_t(7'h21, 3'b000, 4, 1, 2), 32'h5, 32'h1, 4, 32'h0, 0, 1};
        vt[21] = '{{12'h0, 5'd1, 3'b010, 5'd4, 7'b0000011}, 32'h5, 32'h1, 4, 32'h0, 0, 1};
`ifdef ALU_RV_MUL_EN
        vt[22] = '{r_t(7'h01, 3'b001, 10, 1, 2), 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 32'h00000000, 1, 0};
        vt[23] = '{r_t(7'h01, 3'b011, 10, 1, 2), 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 32'hFFFFFFFE, 1, 0};
        vt[24] = '{r_t(7'h01, 3'b000, 10, 1, 2), 32'h3, 32'hFFFFFFFE, 10, 32'hFFFFFFFA, 1, 0};
        vt[25] = '{r_t(7'h01, 3'b010, 10, 1, 2), 32'hFFFFFFFF, 32'h2, 10, 32'hFFFFFFFF, 1, 0};
`else
        vt[22] = '{r_t(7'h01, 3'b001, 10, 1, 2), 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 32'h0, 0, 1};
        vt[23] = '{r_t(7'h01, 3'b011, 10, 1, 2), 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 32'h0, 0, 1};
        vt[24] = '{r_t(7'h01, 3'b000, 10, 1, 2), 32'h3, 32'hFFFFFFFE, 10, 32'h0, 0, 1};
        vt[25] = '{r_t(7'h01, 3'b010, 10, 1, 2), 32'hFFFFFFFF, 32'h2, 10, 32'h0, 0, 1};
`endif
        vt[26] = '{r_t(7'h01, 3'b100, 10, 1, 2), 32'h3, 32'h3, 10, 32'h0, 0, 1};
        vt[27] = '{r_t(7'h20, 3'b001, 4, 1, 2), 32'h1, 32'h1, 4, 32'h0, 0, 1};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = '0; in_tag = '0; rs1_value = '0; rs2_value = '0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_rd", out_rd, 0);
        chk("reset_out_we", out_we, 0);
        chk("reset_out_illegal", out_illegal, 0);
        chk("reset_out_tag", out_tag, 0);

        for (int i = 0; i < 28; i++) apply($sformatf("vec%0d", i), vt[i], 32'h100 + i);

        for (int k = 0; k < 4; k++)
            st[k] = '{i_t(12'(k + 1), 3'b000, 5'(k + 1), 0), 32'h0, 32'hDEADBEEF, 5'(k + 1), 32'(k + 1), 1, 0};
        run_stream("stall", 4, 3);

        st[0] = vt[21];
        st[1] = '{r_t(7'h00, 3'b000, 3, 1, 2), 32'h2, 32'h3, 3, 32'h5, 1, 0};
        st[2] = vt[20];
        st[3] = '{i_t(12'h007, 3'b000, 2, 0), 32'h0, 32'h0, 2, 32'h7, 1, 0};
        run_stream("order", 4, 0);

        out_ready = 1'b0;
        @(negedge clock);
        drive(vt[0], 32'h301);
        @(negedge clock);
        drive(vt[4], 32'h302);
        @(negedge clock);
        drive(vt[5], 32'h303);
        flush = 1'b1;
        #1;
        chk("flush_full_valid", out_valid, 1);
        chk("flush_in_ready", in_ready, 0);
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        apply("after_flush", '{i_t(12'h009, 3'b000, 1, 0), 32'h0, 32'h0, 1, 32'h9, 1, 0}, 32'h304);
        @(negedge clock);
        chk("after_flush_drained", out_valid, 0);

        out_ready = 1'b0;
        @(negedge clock);
        drive(vt[0], 32'h401);
        @(negedge clock);
        drive(vt[4], 32'h402);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset_pre_valid", out_valid, 1);
        chk("midreset_in_ready", in_ready, 0);
        @(negedge clock);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_result", out_result, 0);
        chk("midreset_out_rd", out_rd, 0);
        chk("midreset_out_we", out_we, 0);
        chk("midreset_out_illegal", out_illegal, 0);
        chk("midreset_out_tag", out_tag, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midreset_release_ready", in_ready, 1);
        @(negedge clock);
        @(negedge clock);
        chk("midreset_no_ghost", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
